// File: rtl/cde_jtag_rpc_reg.sv
// cde_jtag_rpc_reg: JTAG RPC data registers (address, data, chip ID)
// turning DR scans into single-beat read/write bus commands.
module cde_jtag_rpc_reg #(
    parameter int ADD_WIDTH = 16,
    parameter int DATA_WIDTH = 32,
    parameter int INST_LENGTH = 4,
    parameter logic [INST_LENGTH-1:0] RPC_ADD = 4'b1001,
    parameter logic [INST_LENGTH-1:0] RPC_DATA = 4'b1010,
    parameter logic [INST_LENGTH-1:0] CHIP_ID_ACCESS = 4'b0011,
    parameter logic [31:0] CHIP_ID_VAL = 32'h0000_0001
) (
    input  logic                   clk,
    input  logic                   trst_n_pad_in,
    input  logic                   tdi_pad_in,
    input  logic                   capture_dr,
    input  logic                   shift_dr,
    input  logic                   update_dr,
    input  logic                   test_logic_reset,
    input  logic [INST_LENGTH-1:0] instruction,
    output logic                   tdo,
    output logic                   cmd_valid,
    input  logic                   cmd_ready,
    output logic                   cmd_wr,
    output logic [ADD_WIDTH-1:0]   cmd_addr,
    output logic [DATA_WIDTH-1:0]  cmd_wdata,
    input  logic                   rsp_valid,
    input  logic [DATA_WIDTH-1:0]  rsp_rdata
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic [ADD_WIDTH+1:0]  add_sr_q, add_sr_d;
    logic [DATA_WIDTH:0]   dat_sr_q, dat_sr_d;
    logic [31:0]           id_sr_q, id_sr_d;
    logic [ADD_WIDTH-1:0]  addr_q, addr_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic                  wr_mode_q, wr_mode_d;
    logic                  ovr_q, ovr_d;
    logic                  cmd_wr_q, cmd_wr_d;
    logic [ADD_WIDTH-1:0]  cmd_addr_q, cmd_addr_d;
    logic [DATA_WIDTH-1:0] cmd_wdata_q, cmd_wdata_d;

    logic sel_add, sel_dat, sel_id;
    logic busy;
    logic data_go;

    assign sel_add = (instruction == RPC_ADD);
    assign sel_dat = (instruction == RPC_DATA);
    assign sel_id  = (instruction == CHIP_ID_ACCESS);
    assign busy    = (state_q != IDLE);
    assign data_go = update_dr && sel_dat && !busy;

    assign cmd_wr    = cmd_wr_q;
    assign cmd_addr  = cmd_addr_q;
    assign cmd_wdata = cmd_wdata_q;

    // Serial output: bit 0 of whichever DR the instruction selects.
    always_comb begin
        tdo = 1'b0;
        if (sel_add) begin
            tdo = add_sr_q[0];
        end else if (sel_dat) begin
            tdo = dat_sr_q[0];
        end else if (sel_id) begin
            tdo = id_sr_q[0];
        end
    end

    // Shift registers: capture parallel status, shift right from TDI.
    always_comb begin
        add_sr_d = add_sr_q;
        dat_sr_d = dat_sr_q;
        id_sr_d  = id_sr_q;
        if (sel_add) begin
            if (capture_dr) begin
                add_sr_d = {addr_q, ovr_q, busy};
            end else if (shift_dr) begin
                add_sr_d = {tdi_pad_in, add_sr_q[ADD_WIDTH+1:1]};
            end
        end
        if (sel_dat) begin
            if (capture_dr) begin
                dat_sr_d = {rdata_q, busy};
            end else if (shift_dr) begin
                dat_sr_d = {tdi_pad_in, dat_sr_q[DATA_WIDTH:1]};
            end
        end
        if (sel_id) begin
            if (capture_dr) begin
                id_sr_d = CHIP_ID_VAL;
            end else if (shift_dr) begin
                id_sr_d = {tdi_pad_in, id_sr_q[31:1]};
            end
        end
    end

    // Update handling, command field latching and read data return.
    always_comb begin
        addr_d      = addr_q;
        wr_mode_d   = wr_mode_q;
        ovr_d       = ovr_q;
        rdata_d     = rdata_q;
        cmd_wr_d    = cmd_wr_q;
        cmd_addr_d  = cmd_addr_q;
        cmd_wdata_d = cmd_wdata_q;
        if (update_dr && sel_add) begin
            if (busy) begin
                ovr_d = 1'b1;
            end else begin
                wr_mode_d = add_sr_q[0];
                addr_d    = add_sr_q[ADD_WIDTH+1:2];
                if (add_sr_q[1]) begin
                    ovr_d = 1'b0;
                end
            end
        end
        if (update_dr && sel_dat) begin
            if (busy) begin
                ovr_d = 1'b1;
            end else begin
                cmd_wr_d   = wr_mode_q;
                cmd_addr_d = addr_q;
                if (wr_mode_q) begin
                    cmd_wdata_d = dat_sr_q[DATA_WIDTH:1];
                end
                addr_d = addr_q + ADD_WIDTH'(1);
            end
        end
        if (state_q == WAIT && rsp_valid && !cmd_wr_q) begin
            rdata_d = rsp_rdata;
        end
        // TAP reset clears the scan-side setup but lets a command finish.
        if (test_logic_reset) begin
            addr_d    = '0;
            wr_mode_d = 1'b0;
            ovr_d     = 1'b0;
        end
    end

    // Command FSM next state and request strobe.
    always_comb begin
        state_d   = state_q;
        cmd_valid = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (data_go) begin
                    state_d = REQ;
                end
            end
            REQ: begin
                cmd_valid = 1'b1;
                if (cmd_ready) begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (rsp_valid) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State registers, cleared asynchronously by TRST.
    always_ff @(posedge clk or negedge trst_n_pad_in) begin
        if (!trst_n_pad_in) begin
            state_q     <= IDLE;
            add_sr_q    <= '0;
            dat_sr_q    <= '0;
            id_sr_q     <= '0;
            addr_q      <= '0;
            rdata_q     <= '0;
            wr_mode_q   <= 1'b0;
            ovr_q       <= 1'b0;
            cmd_wr_q    <= 1'b0;
            cmd_addr_q  <= '0;
            cmd_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            add_sr_q    <= add_sr_d;
            dat_sr_q    <= dat_sr_d;
            id_sr_q     <= id_sr_d;
            addr_q      <= addr_d;
            rdata_q     <= rdata_d;
            wr_mode_q   <= wr_mode_d;
            ovr_q       <= ovr_d;
            cmd_wr_q    <= cmd_wr_d;
            cmd_addr_q  <= cmd_addr_d;
            cmd_wdata_q <= cmd_wdata_d;
        end
    end

endmodule

// File: tb/tb_cde_jtag_rpc_reg.sv
// tb_cde_jtag_rpc_reg: scenario tasks plus randomized transactions
// checked against a scan-level model of the RPC register block.
module tb_cde_jtag_rpc_reg;

    localparam logic [3:0] I_ADD  = 4'b1001;
    localparam logic [3:0] I_DAT  = 4'b1010;
    localparam logic [3:0] I_ID   = 4'b0011;
    localparam logic [3:0] I_BYP  = 4'b1111;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        tdi = 1'b0;
    logic        capture_dr = 1'b0;
    logic        shift_dr = 1'b0;
    logic        update_dr = 1'b0;
    logic        tlr = 1'b0;
    logic [3:0]  instruction = I_BYP;
    logic        tdo;
    logic        cmd_valid;
    logic        cmd_ready = 1'b0;
    logic        cmd_wr;
    logic [15:0] cmd_addr;
    logic [31:0] cmd_wdata;
    logic        rsp_valid = 1'b0;
    logic [31:0] rsp_rdata = '0;

    int total = 0;
    int bad = 0;

    // Model of the architecturally visible state
    logic [15:0] m_addr;
    logic        m_wr;
    logic        m_ovr;
    logic [31:0] m_rdata;
    logic [31:0] m_wdata;

    always #5 clk = ~clk;

    cde_jtag_rpc_reg dut (
        .clk              (clk),
        .trst_n_pad_in    (rst_n),
        .tdi_pad_in       (tdi),
        .capture_dr       (capture_dr),
        .shift_dr         (shift_dr),
        .update_dr        (update_dr),
        .test_logic_reset (tlr),
        .instruction      (instruction),
        .tdo              (tdo),
        .cmd_valid        (cmd_valid),
        .cmd_ready        (cmd_ready),
        .cmd_wr           (cmd_wr),
        .cmd_addr         (cmd_addr),
        .cmd_wdata        (cmd_wdata),
        .rsp_valid        (rsp_valid),
        .rsp_rdata        (rsp_rdata)
    );

    // One DR scan; entered and left at a falling edge.
    task automatic scan(input logic [3:0] ins, input int w,
                        input logic [63:0] din, input bit cap,
                        input bit upd, output logic [63:0] dout);
        dout = '0;
        instruction = ins;
        if (cap) begin
            capture_dr = 1'b1;
            @(posedge clk);
            @(negedge clk);
            capture_dr = 1'b0;
        end
        for (int i = 0; i < w; i++) begin
            dout[i] = tdo;
            tdi = din[i];
            shift_dr = 1'b1;
            @(posedge clk);
            @(negedge clk);
        end
        shift_dr = 1'b0;
        if (upd) begin
            update_dr = 1'b1;
            @(posedge clk);
            @(negedge clk);
            update_dr = 1'b0;
        end
    endtask

    task automatic cycles(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    task automatic pulse_ready();
        cmd_ready = 1'b1;
        @(negedge clk);
        cmd_ready = 1'b0;
    endtask

    task automatic pulse_rsp(input logic [31:0] d);
        rsp_valid = 1'b1;
        rsp_rdata = d;
        @(negedge clk);
        rsp_valid = 1'b0;
    endtask

    // Model step for a data update accepted while idle
    task automatic model_issue(input logic [31:0] d);
        if (m_wr) m_wdata = d;
        m_addr = m_addr + 16'd1;
    endtask

    task automatic model_reset();
        m_addr = '0;
        m_wr = 1'b0;
        m_ovr = 1'b0;
        m_rdata = '0;
        m_wdata = '0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        model_reset();
        cycles(2);
        total++;
        if ({tdo, cmd_valid, cmd_wr, cmd_addr, cmd_wdata} !== '0) begin
            bad++;
            $display("FAIL reset_outputs got=%h exp=0",
                     {tdo, cmd_valid, cmd_wr, cmd_addr, cmd_wdata});
        end
        rst_n = 1'b1;
        cycles(1);
    endtask

    task automatic test_chip_id();
        logic [63:0] o;
        scan(I_ID, 32, 64'($urandom), 1'b1, 1'b1, o);
        total++;
        if (o[31:0] !== 32'h0000_0001) begin
            bad++;
            $display("FAIL chip_id_1 got=%h exp=00000001", o[31:0]);
        end
        scan(I_ID, 32, 64'($urandom), 1'b1, 1'b0, o);
        total++;
        if (o[31:0] !== 32'h0000_0001) begin
            bad++;
            $display("FAIL chip_id_2 got=%h exp=00000001", o[31:0]);
        end
    endtask

    task automatic test_write();
        logic [63:0] o;
        logic [49:0] snap;
        scan(I_ADD, 18, {46'b0, 16'h1234, 1'b0, 1'b1}, 1'b1, 1'b1, o);
        m_addr = 16'h1234;
        m_wr = 1'b1;
        scan(I_DAT, 33, {31'b0, 32'hCAFE_F00D, 1'b0}, 1'b1, 1'b1, o);
        model_issue(32'hCAFE_F00D);
        snap = {1'b1, 1'b1, 16'h1234, 32'hCAFE_F00D};
        total++;
        if ({cmd_valid, cmd_wr, cmd_addr, cmd_wdata} !== snap) begin
            bad++;
            $display("FAIL write_cmd got=%h exp=%h",
                     {cmd_valid, cmd_wr, cmd_addr, cmd_wdata}, snap);
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            total++;
            if ({cmd_valid, cmd_wr, cmd_addr, cmd_wdata} !== snap) begin
                bad++;
                $display("FAIL write_hold%0d got=%h exp=%h", i,
                         {cmd_valid, cmd_wr, cmd_addr, cmd_wdata}, snap);
            end
        end
        pulse_ready();
        total++;
        if (cmd_valid !== 1'b0) begin
            bad++;
            $display("FAIL write_valid_drop got=%b exp=0", cmd_valid);
        end
        cycles(2);
        pulse_rsp(32'h1111_2222);
        scan(I_ADD, 18, '0, 1'b1, 1'b0, o);
        total++;
        if (o[17:0] !== {16'h1235, 1'b0, 1'b0}) begin
            bad++;
            $display("FAIL write_addr_inc got=%h exp=%h",
                     o[17:0], {16'h1235, 2'b00});
        end
    endtask

    task automatic test_read_wrap();
        logic [63:0] o;
        scan(I_ADD, 18, {46'b0, 16'hFFFF, 1'b0, 1'b0}, 1'b1, 1'b1, o);
        m_addr = 16'hFFFF;
        m_wr = 1'b0;
        scan(I_DAT, 33, {31'b0, 32'h0BAD_0BAD, 1'b0}, 1'b1, 1'b1, o);
        model_issue(32'h0BAD_0BAD);
        total++;
        if ({cmd_valid, cmd_wr, cmd_addr, cmd_wdata} !==
            {1'b1, 1'b0, 16'hFFFF, m_wdata}) begin
            bad++;
            $display("FAIL read_cmd got=%h exp=%h",
                     {cmd_valid, cmd_wr, cmd_addr, cmd_wdata},
                     {1'b1, 1'b0, 16'hFFFF, m_wdata});
        end
        pulse_rsp(32'hDEAD_BEEF);
        total++;
        if (cmd_valid !== 1'b1) begin
            bad++;
            $display("FAIL rsp_in_req got=%b exp=1", cmd_valid);
        end
        pulse_ready();
        pulse_rsp(32'hA5A5_5A5A);
        m_rdata = 32'hA5A5_5A5A;
        scan(I_DAT, 33, '0, 1'b1, 1'b0, o);
        total++;
        if (o[32:0] !== {32'hA5A5_5A5A, 1'b0}) begin
            bad++;
            $display("FAIL read_data got=%h exp=%h",
                     o[32:0], {32'hA5A5_5A5A, 1'b0});
        end
        scan(I_ADD, 18, '0, 1'b1, 1'b0, o);
        total++;
        if (o[17:0] !== 18'h0) begin
            bad++;
            $display("FAIL addr_wrap got=%h exp=0", o[17:0]);
        end
    endtask

    task automatic test_overrun();
        logic [63:0] o;
        scan(I_ADD, 18, {46'b0, 16'h0040, 1'b0, 1'b1}, 1'b1, 1'b1, o);
        m_addr = 16'h0040;
        m_wr = 1'b1;
        scan(I_DAT, 33, {31'b0, 32'h1357_9BDF, 1'b0}, 1'b1, 1'b1, o);
        model_issue(32'h1357_9BDF);
        pulse_ready();
        scan(I_DAT, 33, {31'b0, 32'hFFFF_0000, 1'b0}, 1'b1, 1'b1, o);
        m_ovr = 1'b1;
        total++;
        if (o[0] !== 1'b1) begin
            bad++;
            $display("FAIL busy_capture got=%b exp=1", o[0]);
        end
        for (int i = 0; i < 2; i++) begin
            total++;
            if (cmd_valid !== 1'b0) begin
                bad++;
                $display("FAIL no_second_cmd got=%b exp=0", cmd_valid);
            end
            @(negedge clk);
        end
        pulse_rsp(32'h0);
        scan(I_ADD, 18, '0, 1'b1, 1'b0, o);
        total++;
        if (o[17:0] !== {m_addr, 1'b1, 1'b0}) begin
            bad++;
            $display("FAIL overrun_set got=%h exp=%h",
                     o[17:0], {m_addr, 2'b10});
        end
        scan(I_ADD, 18, {46'b0, 16'h0777, 1'b1, 1'b0}, 1'b1, 1'b1, o);
        m_addr = 16'h0777;
        m_wr = 1'b0;
        m_ovr = 1'b0;
        scan(I_ADD, 18, '0, 1'b1, 1'b0, o);
        total++;
        if (o[17:0] !== {16'h0777, 2'b00}) begin
            bad++;
            $display("FAIL overrun_clear got=%h exp=%h",
                     o[17:0], {16'h0777, 2'b00});
        end
    endtask

    task automatic test_tlr();
        logic [63:0] o;
        scan(I_ADD, 18, {46'b0, 16'h2468, 1'b0, 1'b1}, 1'b1, 1'b1, o);
        m_addr = 16'h2468;
        m_wr = 1'b1;
        scan(I_DAT, 33, {31'b0, 32'h0F0F_0F0F, 1'b0}, 1'b1, 1'b1, o);
        model_issue(32'h0F0F_0F0F);
        tlr = 1'b1;
        @(negedge clk);
        tlr = 1'b0;
        m_addr = '0;
        m_wr = 1'b0;
        m_ovr = 1'b0;
        total++;
        if ({cmd_valid, cmd_wr, cmd_addr} !== {1'b1, 1'b1, 16'h2468}) begin
            bad++;
            $display("FAIL tlr_cmd_kept got=%h exp=%h",
                     {cmd_valid, cmd_wr, cmd_addr}, {2'b11, 16'h2468});
        end
        scan(I_ADD, 18, '0, 1'b1, 1'b0, o);
        total++;
        if (o[17:0] !== 18'h1) begin
            bad++;
            $display("FAIL tlr_addr got=%h exp=00001", o[17:0]);
        end
        pulse_ready();
        pulse_rsp(32'h0);
        scan(I_ADD, 18, '0, 1'b1, 1'b0, o);
        total++;
        if (o[17:0] !== 18'h0) begin
            bad++;
            $display("FAIL tlr_done got=%h exp=0", o[17:0]);
        end
    endtask

    task automatic test_trst_abort();
        logic [63:0] o;
        scan(I_ADD, 18, {46'b0, 16'h5555, 1'b0, 1'b1}, 1'b1, 1'b1, o);
        scan(I_DAT, 33, {31'b0, 32'h7777_8888, 1'b0}, 1'b1, 1'b1, o);
        #1;
        rst_n = 1'b0;
        #1;
        model_reset();
        total++;
        if ({tdo, cmd_valid, cmd_wr, cmd_addr, cmd_wdata} !== '0) begin
            bad++;
            $display("FAIL trst_abort got=%h exp=0",
                     {tdo, cmd_valid, cmd_wr, cmd_addr, cmd_wdata});
        end
        @(negedge clk);
        rst_n = 1'b1;
        cycles(1);
    endtask

    task automatic test_bypass();
        logic [63:0] cap;
        logic [63:0] o;
        logic        seen;
        scan(I_ADD, 18, {46'b0, 16'h3C3C, 1'b1, 1'b0}, 1'b1, 1'b1, o);
        m_addr = 16'h3C3C;
        m_wr = 1'b0;
        m_ovr = 1'b0;
        scan(I_ADD, 0, '0, 1'b1, 1'b0, cap);
        instruction = I_BYP;
        seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tdi = 1'b1;
            shift_dr = 1'b1;
            seen = seen | tdo;
            @(posedge clk);
            @(negedge clk);
        end
        shift_dr = 1'b0;
        total++;
        if (seen !== 1'b0) begin
            bad++;
            $display("FAIL bypass_tdo got=%b exp=0", seen);
        end
        scan(I_ADD, 18, '0, 1'b0, 1'b0, o);
        total++;
        if (o[17:0] !== {16'h3C3C, 2'b00}) begin
            bad++;
            $display("FAIL bypass_hold got=%h exp=%h",
                     o[17:0], {16'h3C3C, 2'b00});
        end
    endtask

    task automatic test_random();
        logic [63:0] o;
        logic [15:0] a;
        logic        w;
        logic [31:0] d;
        logic [31:0] r;
        for (int n = 0; n < 10; n++) begin
            a = 16'($urandom);
            w = 1'($urandom);
            d = $urandom;
            r = $urandom;
            scan(I_ADD, 18, {46'b0, a, 1'b1, w}, 1'b1, 1'b1, o);
            m_addr = a;
            m_wr = w;
            m_ovr = 1'b0;
            scan(I_DAT, 33, {31'b0, d, 1'b0}, 1'b1, 1'b1, o);
            total++;
            if (o[32:0] !== {m_rdata, 1'b0}) begin
                bad++;
                $display("FAIL rnd_cap%0d got=%h exp=%h", n,
                         o[32:0], {m_rdata, 1'b0});
            end
            model_issue(d);
            total++;
            if ({cmd_valid, cmd_wr, cmd_addr, cmd_wdata} !==
                {1'b1, w, a, m_wdata}) begin
                bad++;
                $display("FAIL rnd_cmd%0d got=%h exp=%h", n,
                         {cmd_valid, cmd_wr, cmd_addr, cmd_wdata},
                         {1'b1, w, a, m_wdata});
            end
            cycles($urandom_range(0, 3));
            pulse_ready();
            total++;
            if (cmd_valid !== 1'b0) begin
                bad++;
                $display("FAIL rnd_drop%0d got=%b exp=0", n, cmd_valid);
            end
            cycles($urandom_range(0, 3));
            pulse_rsp(r);
            if (!w) m_rdata = r;
            scan(I_ADD, 18, '0, 1'b1, 1'b0, o);
            total++;
            if (o[17:0] !== {m_addr, m_ovr, 1'b0}) begin
                bad++;
                $display("FAIL rnd_addr%0d got=%h exp=%h", n,
                         o[17:0], {m_addr, m_ovr, 1'b0});
            end
        end
        scan(I_DAT, 33, '0, 1'b1, 1'b0, o);
        total++;
        if (o[32:0] !== {m_rdata, 1'b0}) begin
            bad++;
            $display("FAIL rnd_rdata got=%h exp=%h",
                     o[32:0], {m_rdata, 1'b0});
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_chip_id();
        test_write();
        test_read_wrap();
        test_overrun();
        test_tlr();
        test_trst_abort();
        test_bypass();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
